// File: rtl/rf_wb_ctrl.sv
// Register-file writeback controller: arbitrates ALU/load writebacks onto one
// registered write port and keeps a per-register busy scoreboard for issue hazards.
module rf_wb_ctrl #(
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned XLEN       = 32
) (
  input  logic            clk,
  input  logic            reset,
  // issue slot
  input  logic            iss_valid,
  input  logic [4:0]      iss_rs1,
  input  logic [4:0]      iss_rs2,
  input  logic [4:0]      iss_rd,
  input  logic            iss_rs1_en,
  input  logic            iss_rs2_en,
  input  logic            iss_rd_en,
  output logic            iss_ready,
  // ALU writeback
  input  logic            alu_wb_valid,
  input  logic [4:0]      alu_wb_rd,
  input  logic [XLEN-1:0] alu_wb_data,
  output logic            alu_wb_ready,
  // load writeback
  input  logic            mem_wb_valid,
  input  logic [4:0]      mem_wb_rd,
  input  logic [XLEN-1:0] mem_wb_data,
  output logic            mem_wb_ready,
  // register file write port
  output logic [4:0]      rf_rd,
  output logic            rf_rd_en,
  output logic [XLEN-1:0] rf_rd_data,
  output logic [31:0]     sb_busy,
  output logic            wb_err
);

  localparam int unsigned NREG = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned CW   = 8;

  typedef struct packed {
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  logic [NREG-1:0] sb_busy_q, sb_busy_d;
  logic [RW-1:0]   rf_rd_q, rf_rd_d;
  logic            rf_rd_en_q, rf_rd_en_d;
  logic [XLEN-1:0] rf_rd_data_q, rf_rd_data_d;
  logic            wb_err_q, wb_err_d;
  logic [CW-1:0]   starve_q, starve_d;

  logic            alu_gnt, mem_gnt, starve_hit, iss_fire;
  wb_req_t         alu_req, mem_req, win_req;

  assign alu_req = '{rd: alu_wb_rd, data: alu_wb_data};
  assign mem_req = '{rd: mem_wb_rd, data: mem_wb_data};

  // Hazard check against the current scoreboard; independent of iss_valid.
  always_comb begin
    iss_ready = 1'b1;
    if (iss_rs1_en && sb_busy_q[iss_rs1]) iss_ready = 1'b0;
    if (iss_rs2_en && sb_busy_q[iss_rs2]) iss_ready = 1'b0;
    if (iss_rd_en  && sb_busy_q[iss_rd])  iss_ready = 1'b0;
  end

  assign iss_fire = iss_valid && iss_ready;

  // Load wins by default; a starved ALU request wins once.
  always_comb begin
    starve_hit = (starve_q == CW'(STARVE_MAX)) && alu_wb_valid;
    alu_gnt    = alu_wb_valid && (!mem_wb_valid || starve_hit);
    mem_gnt    = mem_wb_valid && !alu_gnt;
    win_req    = alu_gnt ? alu_req : mem_req;
  end

  assign alu_wb_ready = alu_gnt;
  assign mem_wb_ready = mem_gnt;

  // Starvation counter: counts consecutive denied ALU cycles, saturating.
  always_comb begin
    starve_d = starve_q;
    if (!alu_wb_valid || alu_gnt) begin
      starve_d = '0;
    end else if (starve_q < CW'(STARVE_MAX)) begin
      starve_d = starve_q + CW'(1);
    end
  end

  // Write port: index/data hold when idle; x0 writes consume the slot silently.
  always_comb begin
    rf_rd_d      = rf_rd_q;
    rf_rd_data_d = rf_rd_data_q;
    rf_rd_en_d   = 1'b0;
    if (alu_gnt || mem_gnt) begin
      rf_rd_d      = win_req.rd;
      rf_rd_data_d = win_req.data;
      rf_rd_en_d   = (win_req.rd != RW'(0));
    end
  end

  // Scoreboard: clear on landing write, set on issue; set applied last so it wins.
  always_comb begin
    sb_busy_d = sb_busy_q;
    if (rf_rd_en_q) sb_busy_d[rf_rd_q] = 1'b0;
    if (iss_fire && iss_rd_en && (iss_rd != RW'(0))) sb_busy_d[iss_rd] = 1'b1;
    sb_busy_d[0] = 1'b0;
  end

  assign wb_err_d = wb_err_q || (rf_rd_en_q && !sb_busy_q[rf_rd_q]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_busy_q    <= '0;
      rf_rd_q      <= '0;
      rf_rd_en_q   <= 1'b0;
      rf_rd_data_q <= '0;
      wb_err_q     <= 1'b0;
      starve_q     <= '0;
    end else begin
      sb_busy_q    <= sb_busy_d;
      rf_rd_q      <= rf_rd_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_rd_data_q <= rf_rd_data_d;
      wb_err_q     <= wb_err_d;
      starve_q     <= starve_d;
    end
  end

  assign sb_busy    = sb_busy_q;
  assign rf_rd      = rf_rd_q;
  assign rf_rd_en   = rf_rd_en_q;
  assign rf_rd_data = rf_rd_data_q;
  assign wb_err     = wb_err_q;

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed self-checking bench for rf_wb_ctrl.
module tb_rf_wb_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_valid;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_rs1_en, iss_rs2_en, iss_rd_en;
  logic        iss_ready;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        alu_wb_ready;
  logic        mem_wb_valid;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_data;
  logic        mem_wb_ready;
  logic [4:0]  rf_rd;
  logic        rf_rd_en;
  logic [31:0] rf_rd_data;
  logic [31:0] sb_busy;
  logic        wb_err;

  int checks = 0;
  int failures = 0;

  rf_wb_ctrl #(.STARVE_MAX(3), .XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_rs1_en(iss_rs1_en), .iss_rs2_en(iss_rs2_en), .iss_rd_en(iss_rd_en),
    .iss_ready(iss_ready),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .mem_wb_ready(mem_wb_ready),
    .rf_rd(rf_rd), .rf_rd_en(rf_rd_en), .rf_rd_data(rf_rd_data),
    .sb_busy(sb_busy), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
    iss_rs1_en = 0; iss_rs2_en = 0; iss_rd_en = 0;
    alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
    mem_wb_valid = 0; mem_wb_rd = 0; mem_wb_data = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    #12;
    checks++; if (sb_busy !== 32'h0) begin failures++; $display("FAIL reset_sb got=%h exp=%h", sb_busy, 32'h0); end
    checks++; if (rf_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rf_en got=%b exp=0", rf_rd_en); end
    checks++; if (rf_rd !== 5'd0 || rf_rd_data !== 32'h0) begin failures++; $display("FAIL reset_rf got rd=%0d data=%h exp 0/0", rf_rd, rf_rd_data); end
    checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL reset_wb_err got=%b exp=0", wb_err); end
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL reset_iss_ready got=%b exp=1", iss_ready); end
    @(negedge clk);
    reset = 1;
    tick();
  endtask

  task automatic test_issue_raw();
    iss_valid = 1; iss_rd = 5; iss_rd_en = 1;
    #1;
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL issue_x5_ready got=%b exp=1", iss_ready); end
    tick();
    iss_valid = 0; iss_rd_en = 0; iss_rd = 0;
    checks++; if (sb_busy !== 32'h0000_0020) begin failures++; $display("FAIL issue_x5_sb got=%h exp=%h", sb_busy, 32'h20); end
    iss_valid = 1; iss_rs1 = 5; iss_rs1_en = 1;
    #1;
    checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL raw_rs1 got=%b exp=0", iss_ready); end
    iss_rs1_en = 0; iss_rs2 = 5; iss_rs2_en = 1;
    #1;
    checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL raw_rs2 got=%b exp=0", iss_ready); end
    iss_rs2_en = 0; iss_rd = 5; iss_rd_en = 1;
    #1;
    checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL waw_rd got=%b exp=0", iss_ready); end
    iss_rd_en = 0; iss_rd = 0; iss_rs1_en = 1;
  endtask

  task automatic test_alu_wb();
    alu_wb_valid = 1; alu_wb_rd = 5; alu_wb_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (alu_wb_ready !== 1'b1 || mem_wb_ready !== 1'b0) begin failures++; $display("FAIL alu_grant got alu=%b mem=%b exp 1/0", alu_wb_ready, mem_wb_ready); end
    tick();
    alu_wb_valid = 0;
    #1;
    checks++; if (rf_rd !== 5'd5 || rf_rd_en !== 1'b1 || rf_rd_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL alu_write got rd=%0d en=%b data=%h exp 5/1/deadbeef", rf_rd, rf_rd_en, rf_rd_data); end
    checks++; if (sb_busy !== 32'h20 || iss_ready !== 1'b0) begin failures++; $display("FAIL alu_still_busy got sb=%h rdy=%b exp 20/0", sb_busy, iss_ready); end
    tick();
    checks++; if (sb_busy !== 32'h0 || iss_ready !== 1'b1) begin failures++; $display("FAIL alu_cleared got sb=%h rdy=%b exp 0/1", sb_busy, iss_ready); end
    checks++; if (rf_rd_en !== 1'b0 || rf_rd !== 5'd5 || rf_rd_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL port_hold got en=%b rd=%0d data=%h exp 0/5/deadbeef", rf_rd_en, rf_rd, rf_rd_data); end
    idle_inputs();
    tick();
    checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL alu_no_err got=%b exp=0", wb_err); end
  endtask

  task automatic test_x0();
    iss_valid = 1; iss_rd = 0; iss_rd_en = 1;
    tick();
    iss_valid = 0; iss_rd_en = 0;
    checks++; if (sb_busy !== 32'h0) begin failures++; $display("FAIL x0_issue_sb got=%h exp=0", sb_busy); end
    mem_wb_valid = 1; mem_wb_rd = 0; mem_wb_data = 32'h1234_5678;
    #1;
    checks++; if (mem_wb_ready !== 1'b1) begin failures++; $display("FAIL x0_mem_ready got=%b exp=1", mem_wb_ready); end
    tick();
    mem_wb_valid = 0;
    checks++; if (rf_rd_en !== 1'b0) begin failures++; $display("FAIL x0_no_write got=%b exp=0", rf_rd_en); end
    tick();
    checks++; if (wb_err !== 1'b0 || sb_busy !== 32'h0) begin failures++; $display("FAIL x0_after got err=%b sb=%h exp 0/0", wb_err, sb_busy); end
  endtask

  task automatic test_wb_err();
    mem_wb_valid = 1; mem_wb_rd = 7; mem_wb_data = 32'h0000_0777;
    tick();
    mem_wb_valid = 0;
    checks++; if (rf_rd_en !== 1'b1 || rf_rd !== 5'd7 || rf_rd_data !== 32'h777) begin failures++; $display("FAIL err_write got en=%b rd=%0d data=%h exp 1/7/777", rf_rd_en, rf_rd, rf_rd_data); end
    tick();
    checks++; if (wb_err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", wb_err); end
    repeat (3) tick();
    checks++; if (wb_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", wb_err); end
  endtask

  task automatic test_arbitration();
    logic exp_alu;
    alu_wb_valid = 1; alu_wb_rd = 3; alu_wb_data = 32'hAAAA_0003;
    mem_wb_valid = 1; mem_wb_rd = 4; mem_wb_data = 32'hBBBB_0004;
    for (int c = 0; c < 8; c++) begin
      exp_alu = ((c % 4) == 3);
      #1;
      checks++; if (alu_wb_ready !== exp_alu || mem_wb_ready !== !exp_alu) begin failures++; $display("FAIL arb_c%0d got alu=%b mem=%b exp alu=%b", c, alu_wb_ready, mem_wb_ready, exp_alu); end
      tick();
      checks++; if (rf_rd_en !== 1'b1 || rf_rd !== (exp_alu ? 5'd3 : 5'd4) || rf_rd_data !== (exp_alu ? 32'hAAAA_0003 : 32'hBBBB_0004)) begin failures++; $display("FAIL arb_wr_c%0d got en=%b rd=%0d data=%h", c, rf_rd_en, rf_rd, rf_rd_data); end
    end
    // ALU drops its request for a cycle: the starvation count restarts
    for (int c = 0; c < 7; c++) begin
      alu_wb_valid = (c != 2);
      exp_alu = (c == 6);
      #1;
      checks++; if (alu_wb_ready !== exp_alu || mem_wb_ready !== !exp_alu) begin failures++; $display("FAIL starve_clr_c%0d got alu=%b mem=%b exp alu=%b", c, alu_wb_ready, mem_wb_ready, exp_alu); end
      tick();
    end
    idle_inputs();
    tick();
    checks++; if (wb_err !== 1'b1) begin failures++; $display("FAIL arb_err_sticky got=%b exp=1", wb_err); end
  endtask

  task automatic test_async_reset();
    for (int r = 1; r < 16; r++) begin
      iss_valid = 1; iss_rd = 5'(r); iss_rd_en = 1;
      #1;
      checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_x%0d got=%b exp=1", r, iss_ready); end
      tick();
    end
    idle_inputs();
    checks++; if (sb_busy !== 32'h0000_FFFE) begin failures++; $display("FAIL fill_sb got=%h exp=0000fffe", sb_busy); end
    mem_wb_valid = 1; mem_wb_rd = 1; mem_wb_data = 32'h5555_5555;
    #1;
    checks++; if (mem_wb_ready !== 1'b1) begin failures++; $display("FAIL pend_grant got=%b exp=1", mem_wb_ready); end
    #1;
    reset = 0;
    #1;
    checks++; if (sb_busy !== 32'h0 || rf_rd_en !== 1'b0 || wb_err !== 1'b0) begin failures++; $display("FAIL async_rst got sb=%h en=%b err=%b exp 0/0/0", sb_busy, rf_rd_en, wb_err); end
    mem_wb_valid = 0;
    @(negedge clk);
    reset = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (rf_rd_en !== 1'b0 || sb_busy !== 32'h0 || wb_err !== 1'b0) begin failures++; $display("FAIL post_rst_c%0d got en=%b sb=%h err=%b exp 0/0/0", c, rf_rd_en, sb_busy, wb_err); end
    end
  endtask

  initial begin
    test_reset();
    test_issue_raw();
    test_alu_wb();
    test_x0();
    test_wb_err();
    test_arbitration();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
